// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI register bank: named register addresses,
// frame-result encoding and the frame-length helper.
package spi_reg_pkg;

  localparam int REG_LED = 7;
  localparam int REG_MUX = 8;
  localparam int REG_DAC = 9;

  typedef enum logic [1:0] {
    ACCEPT,
    IGNORE,
    ERR
  } frame_res_e;

  function automatic int FRAME_LEN(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser plus one history flop for an asynchronous input;
// produces the synchronised level and single-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic lvl,
  output logic rise,
  output logic fall
);

  // [0],[1] synchroniser stages, [2] history for edge detection
  logic [2:0] sync_q, sync_d;

  assign sync_d = {sync_q[1:0], d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {3{RST_VAL}};
    else     sync_q <= sync_d;
  end

  assign lvl  = sync_q[1];
  assign rise =  sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/spi_reg_bank.sv
// Oversampled SPI-slave register bank: address/data frames are validated at
// cs_n rise and written into the bank. Readback on miso when SPI_REG_READBACK_EN is defined.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter int                NUM_REGS = 16,
  parameter logic [DATA_W-1:0] REG_RST  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         cs_n,
  input  logic                         mosi,
  input  logic                         special,
  output logic                         miso,
  output logic                         miso_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_q,
  output logic                         wr_stb,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err,
  output logic [7:0]                   err_cnt
);

  localparam int FRAME = FRAME_LEN(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(FRAME + 2);
  localparam int AW1   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FRAME);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(FRAME + 1);
  localparam logic [AW1-1:0]   NUM_REGS_W = AW1'(NUM_REGS);

  logic sclk_rise, sclk_fall, cs_s, cs_rise, cs_fall, mosi_s, spec_s;
  logic unused_sclk_lvl, unused_mosi_r, unused_mosi_f, unused_spec_r, unused_spec_f;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d(sclk), .lvl(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .d(cs_n), .lvl(cs_s), .rise(cs_rise), .fall(cs_fall));
  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .d(mosi), .lvl(mosi_s), .rise(unused_mosi_r), .fall(unused_mosi_f));
  spi_sync_edge #(.RST_VAL(1'b0)) u_spec (
    .clk(clk), .rst(rst), .d(special), .lvl(spec_s), .rise(unused_spec_r), .fall(unused_spec_f));

  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [FRAME-1:0]                    sh_q, sh_d;
  logic                                ign_q, ign_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]     reg_q, reg_d;
  logic                                wr_stb_q, wr_stb_d;
  logic                                frame_err_q, frame_err_d;
  logic [ADDR_W-1:0]                   wr_addr_q, wr_addr_d;
  logic [7:0]                          err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]                   f_addr;
  logic [DATA_W-1:0]                   f_data;
  logic                                addr_ok;
  frame_res_e                          res;

  assign f_addr  = sh_q[FRAME-1 -: ADDR_W];
  assign f_data  = sh_q[DATA_W-1:0];
  assign addr_ok = {1'b0, f_addr} < NUM_REGS_W;

  always_comb begin
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    ign_d       = ign_q;
    reg_d       = reg_q;
    wr_stb_d    = 1'b0;
    frame_err_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    err_cnt_d   = err_cnt_q;
    res         = IGNORE;
    if (cs_fall) begin
      cnt_d = '0;
      sh_d  = '0;
      ign_d = spec_s;
    end else if (!cs_s) begin
      if (spec_s) ign_d = 1'b1;
      if (sclk_fall) begin
        sh_d = {sh_q[FRAME-2:0], mosi_s};
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end
    end else if (cs_rise) begin
      // cs glitches (no clocks at all) are dropped rather than counted as errors
      if (ign_q || cnt_q == '0)                res = IGNORE;
      else if (cnt_q != CNT_FULL || !addr_ok)  res = ERR;
      else                                     res = ACCEPT;
      case (res)
        ACCEPT: begin
          for (int i = 0; i < NUM_REGS; i++)
            if (ADDR_W'(i) == f_addr) reg_d[i] = f_data;
          wr_addr_d = f_addr;
          wr_stb_d  = 1'b1;
        end
        ERR: begin
          frame_err_d = 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      sh_q        <= '0;
      ign_q       <= 1'b0;
      reg_q       <= {NUM_REGS{REG_RST}};
      wr_stb_q    <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      ign_q       <= ign_d;
      reg_q       <= reg_d;
      wr_stb_q    <= wr_stb_d;
      frame_err_q <= frame_err_d;
      wr_addr_q   <= wr_addr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign regs_q    = reg_q;
  assign wr_stb    = wr_stb_q;
  assign frame_err = frame_err_q;
  assign wr_addr   = wr_addr_q;
  assign err_cnt   = err_cnt_q;

`ifdef SPI_REG_READBACK_EN
  logic [DATA_W-1:0] rb_q, rb_d, rb_load;
  logic              rb_hold_q, rb_hold_d;
  logic [ADDR_W-1:0] rb_addr;

  assign rb_addr = {sh_q[ADDR_W-2:0], mosi_s};

  always_comb begin
    rb_load = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (ADDR_W'(i) == rb_addr) rb_load = reg_q[i];
  end

  // The load lands just before the first data-bit rise; that rise must not
  // shift, so the MSB stays on miso for the master's first data sample.
  always_comb begin
    rb_d      = rb_q;
    rb_hold_d = rb_hold_q;
    if (cs_fall) begin
      rb_d      = '0;
      rb_hold_d = 1'b0;
    end else if (!cs_s && sclk_fall && cnt_q == CNT_W'(ADDR_W - 1)) begin
      rb_d      = rb_load;
      rb_hold_d = 1'b1;
    end else if (sclk_rise) begin
      if (rb_hold_q) rb_hold_d = 1'b0;
      else           rb_d      = {rb_q[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_q      <= '0;
      rb_hold_q <= 1'b0;
    end else begin
      rb_q      <= rb_d;
      rb_hold_q <= rb_hold_d;
    end
  end

  assign miso    = rb_q[DATA_W-1];
  assign miso_oe = !cs_s && !spec_s;
`else
  logic unused_rise;
  assign unused_rise = sclk_rise;
  assign miso        = 1'b0;
  assign miso_oe     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: directed frames then random frames
// against a frame-level reference model of the register bank.
module tb_spi_reg_bank;
  import spi_reg_pkg::*;

  localparam int AW = 8, DW = 8, NR = 16, H = 6;

  logic clk = 1'b0;
  logic rst, sclk, cs_n, mosi, special;
  logic miso, miso_oe, wr_stb, frame_err;
  logic [NR*DW-1:0] regs_q;
  logic [AW-1:0]    wr_addr;
  logic [7:0]       err_cnt;

  int checks = 0, errors = 0;
  int wr_seen = 0, err_seen = 0, both_seen = 0;
  logic [7:0] mregs [NR];
  int         m_err;
  logic [7:0] m_waddr;
  bit         rb_en;

  spi_reg_bank #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .REG_RST(8'h00)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .special(special),
    .miso(miso), .miso_oe(miso_oe), .regs_q(regs_q), .wr_stb(wr_stb),
    .wr_addr(wr_addr), .frame_err(frame_err), .err_cnt(err_cnt));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb) wr_seen++;
    if (frame_err) err_seen++;
    if (wr_stb && frame_err) both_seen++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mflat();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = mregs[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mregs[i] = 8'h00;
    m_err   = 0;
    m_waddr = 8'h00;
  endtask

  // Master side: mosi changes with sclk rise, miso captured just before each fall.
  task automatic spi_frame(input logic [31:0] word, input int nbits, input bit sp,
                           output logic [7:0] cap);
    cap  = 8'h00;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      sclk = 1'b1;
      mosi = word[i];
      if (sp && i == nbits / 2) special = 1'b1;
      repeat (H) @(negedge clk);
      if (!sp && i == nbits - 1) chk("miso_oe_mid", 128'(miso_oe), 128'(rb_en));
      if (i < DW) cap = {cap[6:0], miso};
      sclk = 1'b0;
      repeat (H) @(negedge clk);
      special = 1'b0;
    end
    repeat (2) @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input logic [31:0] word, input int nbits, input bit sp);
    logic [7:0] cap, exp_cap;
    int w0, e0, a, exp_w, exp_e;
    a  = int'(word[15:8]);
    w0 = wr_seen;
    e0 = err_seen;
    exp_cap = (rb_en && a < NR) ? mregs[a] : 8'h00;
    spi_frame(word, nbits, sp, cap);
    exp_w = 0;
    exp_e = 0;
    if (!sp && nbits != 0) begin
      if (nbits != AW + DW || a >= NR) exp_e = 1;
      else                             exp_w = 1;
    end
    if (exp_w == 1) begin
      mregs[a] = word[7:0];
      m_waddr  = 8'(a);
    end
    if (exp_e == 1 && m_err < 255) m_err++;
    chk({tag, "_wr_stb"},  128'(wr_seen - w0),  128'(exp_w));
    chk({tag, "_ferr"},    128'(err_seen - e0), 128'(exp_e));
    chk({tag, "_err_cnt"}, 128'(err_cnt),       128'(m_err));
    chk({tag, "_regs"},    regs_q,              mflat());
    chk({tag, "_wr_addr"}, 128'(wr_addr),       128'(m_waddr));
    if (!sp && nbits == AW + DW) chk({tag, "_miso"}, 128'(cap), 128'(exp_cap));
  endtask

  initial begin
    logic [31:0] w;
    int nb, pick, a;
    bit sp;
`ifdef SPI_REG_READBACK_EN
    rb_en = 1'b1;
`else
    rb_en = 1'b0;
`endif
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; special = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    chk("rst_regs", regs_q, mflat());
    chk("rst_wr_stb", 128'(wr_stb), 128'(0));
    chk("rst_ferr", 128'(frame_err), 128'(0));
    chk("rst_wr_addr", 128'(wr_addr), 128'(0));
    chk("rst_err_cnt", 128'(err_cnt), 128'(0));
    chk("rst_miso", 128'({miso, miso_oe}), 128'(0));
    rst = 1'b0;
    repeat (5) @(negedge clk);

    run_frame("wr_led", {16'h0, 8'(REG_LED), 8'h03}, 16, 1'b0);
    run_frame("short15", 32'h0000_0812, 15, 1'b0);
    run_frame("long17", 32'h0001_0812, 17, 1'b0);
    chk("two_errs", 128'(err_cnt), 128'(2));
    run_frame("special", 32'h0000_0855, 16, 1'b1);
    run_frame("bad_addr", 32'h0000_2077, 16, 1'b0);
    run_frame("glitch", 32'h0, 0, 1'b0);

    // reset in the middle of a frame
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 15; i >= 7; i--) begin
      sclk = 1'b1; mosi = w[0] ^ 1'b1;
      repeat (H) @(negedge clk);
      sclk = 1'b0;
      repeat (H) @(negedge clk);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    cs_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("midrst_regs", regs_q, mflat());
    chk("midrst_err_cnt", 128'(err_cnt), 128'(0));
    chk("midrst_wr_addr", 128'(wr_addr), 128'(0));
    chk("midrst_miso", 128'({miso, miso_oe}), 128'(0));
    rst = 1'b0;
    repeat (5) @(negedge clk);
    run_frame("wr_dac", {16'h0, 8'(REG_DAC), 8'h0F}, 16, 1'b0);

    run_frame("rb_a5", 32'h0000_07A5, 16, 1'b0);
    run_frame("rb_3c", 32'h0000_073C, 16, 1'b0);

    for (int n = 0; n < 30; n++) begin
      pick = int'($urandom_range(0, 9));
      if (pick <= 5)      nb = 16;
      else if (pick == 6) nb = 0;
      else if (pick == 7) nb = 15;
      else if (pick == 8) nb = 17;
      else                nb = int'($urandom_range(1, 20));
      a  = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, NR - 1)) : int'($urandom_range(NR, 255));
      w  = {16'($urandom), 8'(a), 8'($urandom)};
      sp = ($urandom_range(0, 7) == 0);
      run_frame("rand", w, nb, sp);
    end

    chk("stb_and_err_overlap", 128'(both_seen), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

Parametrised SPI-slave register bank: accepts address/data frames from the MCU over SPI and latches them into a bank of control registers (LED, mux, DAC control lines, …) in the FPGA system clock domain. It replaces the previous latch-on-CS register bank with a fully synchronous, oversampled design. The new design validates the bit count of every frame and reports framing errors. It sits directly behind the top-level SPI pins, and its register outputs fan out to the board control signals.

## Interface
- `ADDR_W`, 8, address field width in bits (sent first, MSB-first).
- `DATA_W`, 8, data field width in bits.
- `NUM_REGS`, 16, number of implemented registers; addresses ≥ NUM_REGS are invalid.
- `REG_RST`, 0, reset value of every register (DATA_W bits).
- `clk`  in  1  system clock (XTALCLK); must be ≥ 4× SPI clock.
- `rst`  in  1  asynchronous, active-high reset.
- `sclk`  in  1  SPI clock, asynchronous to clk, idle low.
- `cs_n`  in  1  SPI chip select, active low, asynchronous.
- `mosi`  in  1  SPI data in, asynchronous.
- `special`  in  1  high = frame belongs to another peripheral; the bank must ignore it.
- `miso`  out  1  readback data (see Configuration).
- `miso_oe`  out  1  miso drive enable.
- `regs_q`  out  NUM_REGS*DATA_W  flattened register contents, reg i at [i*DATA_W +: DATA_W].
- `wr_stb`  out  1  one-cycle pulse on each accepted write.
- `wr_addr`  out  ADDR_W  address of the last accepted write.
- `frame_err`  out  1  one-cycle pulse on each rejected frame.
- `err_cnt`  out  8  saturating count of rejected frames.

## Operation
- Synchronisation: `sclk`, `cs_n`, `mosi` and `special` each pass through a 2-flop synchroniser, then one history flop for edge detection.
- Frame start: a synchronised falling edge of `cs_n` clears the bit counter, the shift register and the `ign` flag.
- Ignore flag: `ign` is set if synchronised `special` is high on any clk cycle while `cs_n` is low.
- Shifting: on each detected `sclk` falling edge with `cs_n` low, shift left and insert `mosi` at the LSB. The bit counter saturates at ADDR_W+DATA_W+1.
- Frame end: on a synchronised `cs_n` rising edge, evaluate in this priority order:
  - `ign` set: drop the frame silently.
  - Counter = 0: drop the frame silently, treated as a CS glitch.
  - Counter ≠ ADDR_W+DATA_W: assert `frame_err`, increment `err_cnt`.
  - Address ≥ NUM_REGS: assert `frame_err`, increment `err_cnt`.
  - Otherwise: write `regs[addr] <= data`, set `wr_addr <= addr`, pulse `wr_stb`.
- Register updates happen only at frame end; a partial frame never alters `regs_q`.
- `err_cnt` saturates at 255 and clears only on reset.
- Frame start and frame end cannot occur in the same cycle; the edge detector sees one `cs_n` edge per cycle.
- Reset, including mid-frame: the frame is abandoned and all state is cleared.
  - All registers = REG_RST.
  - `wr_stb` = 0, `frame_err` = 0, `wr_addr` = 0, `err_cnt` = 0.
  - `miso` = 0, `miso_oe` = 0.
  - Bit counter = 0; `ign` = 0.

## Timing
- SPI mode: master changes `mosi` on `sclk` rise; the bank samples on `sclk` fall.
- Pin-to-detect latency: `cs_n` or `sclk` edges are detected 3 clk edges after the pin changes, with +1 cycle metastability uncertainty.
- Write visibility: `regs_q` and `wr_stb` update on the same clk edge that detects `cs_n` rise. The new value is valid on the following cycle.
- Pulse widths: `wr_stb` and `frame_err` are exactly one cycle wide, and are never asserted together.
- Minimum SPI timing: `sclk` high and low each ≥ 2 clk periods. `cs_n` high between frames ≥ 2 clk periods.

## Configuration
- `SPI_REG_READBACK_EN` defined: readback is compiled in.
  - When the counter reaches ADDR_W with a valid address, load the readback shifter with `regs[addr]`. An invalid address loads 0.
  - `miso` presents the shifter MSB and advances on each detected `sclk` rise, so the old value appears during the data phase of the same frame.
  - `miso_oe` = synchronised `!cs_n && !special`.
- `SPI_REG_READBACK_EN` undefined: no readback logic is built; `miso` and `miso_oe` are tied to 0.

## Structure
- Package `spi_reg_pkg`:
  - `FRAME_LEN` = ADDR_W+DATA_W helper function.
  - Named register addresses: LED = 7, MUX = 8, DAC = 9.
  - Frame-result enum: ACCEPT, IGNORE, ERR.
- Sub-module `spi_sync_edge`: 2-flop synchroniser plus rise/fall pulse outputs. Instantiated once for each of `sclk` and `cs_n`; `mosi` and `special` use only its synchronised level output.

## Test plan
- Write 0x07_03, 16 bits, special = 0 → `regs_q` reg7 = 0x03, one `wr_stb`, `wr_addr` = 7, `err_cnt` = 0.
- 15-bit frame, then a 17-bit frame → no register change, two `frame_err` pulses, `err_cnt` = 2.
- Frame 0x08_55 with `special` pulsed high mid-frame → no write, no error, `regs_q` unchanged.
- Write to address 0x20 with NUM_REGS = 16 → `frame_err`, `regs_q` unchanged.
- Assert `rst` after 9 bits of a frame, release, then send a full 0x09_0F → all registers = REG_RST after reset; then reg9 = 0x0F and exactly one `wr_stb`.
- With `SPI_REG_READBACK_EN`: write reg7 = 0xA5, then write reg7 = 0x3C → `miso` shifts out 0xA5 during the data phase of the second frame, and reg7 = 0x3C afterwards.
